bus_arbiter: RTL and testbench

Two-master arbiter sharing the single CPU-side system bus (the NorthBridge port: address, write data, write enable, byte enables, read data) between the CPU data port (M0) and a second bus master such as a UART boot loader or DMA engine (M1). It grants the bus to one master at a time and sequences that master's transfers onto the bus, one per cycle. Arbitration is round-robin, with an optional lock for bursts and a burst cap that guarantees fairness. Read data is registered and returned to the owning master one cycle after the transfer.

---
 rtl/bus_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter giving two bus masters (M0 = CPU data
// port, M1 = boot loader / DMA) alternating ownership of the shared system
// bus, with optional burst locking bounded by MAX_BURST. Read data is
// registered and returned to the issuing master one cycle after its ack.
module bus_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        sys_rstn,

  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  output logic        m0_rvalid,

  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic        m1_rvalid,

  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rd,

  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Last transfer index of a locked tenure before a waiting master wins.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last;
  logic [7:0] cnt;
  logic       burst_done;

  // The owner's request is issued straight onto the bus in the same cycle.
  assign m0_ack = (state == OWN0) && m0_req;
  assign m1_ack = (state == OWN1) && m1_req;

  assign owner = (state == OWN1);
  assign busy  = (state != IDLE);

  // cnt saturates, so compare with >= to keep the cap effective even when a
  // tenure started without competition and ran past MAX_BURST transfers.
  assign burst_done = (cnt >= BURST_LAST);

  // Next-state: round-robin on ties, handover on drop, unlock or burst cap.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req)
          state_nxt = m1_req ? OWN1 : IDLE;
        else if (m1_req && (!m0_lock || burst_done))
          state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_req)
          state_nxt = m0_req ? OWN0 : IDLE;
        else if (m0_req && (!m1_lock || burst_done))
          state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared bus mux: the acked master's fields, zeros when nothing is issued.
  always_comb begin
    bus_addr = '0;
    bus_wd   = '0;
    bus_we   = 1'b0;
    bus_be   = '0;
    if (m0_ack) begin
      bus_addr = m0_addr;
      bus_wd   = m0_wd;
      bus_we   = m0_we;
      bus_be   = m0_be;
    end else if (m1_ack) begin
      bus_addr = m1_addr;
      bus_wd   = m1_wd;
      bus_we   = m1_we;
      bus_be   = m1_be;
    end
  end

  // State, round-robin history, tenure counter and registered read return.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      m0_rd     <= '0;
      m1_rd     <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)
        cnt <= '0;
      else if ((m0_ack || m1_ack) && (cnt != '1))
        cnt <= cnt + 8'd1;

      if ((state_nxt != state) && (state_nxt != IDLE))
        last <= (state_nxt == OWN1);

      m0_rvalid <= m0_ack && !m0_we;
      m1_rvalid <= m1_ack && !m1_we;
      if (m0_ack && !m0_we) m0_rd <= bus_rd;
      if (m1_ack && !m1_we) m1_rd <= bus_rd;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural ownership model.
module tb_bus_arbiter;

  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        m0_req, m0_lock, m0_we;
  logic [31:0] m0_addr, m0_wd;
  logic [3:0]  m0_be;
  logic        m0_ack, m0_rvalid;
  logic [31:0] m0_rd;
  logic        m1_req, m1_lock, m1_we;
  logic [31:0] m1_addr, m1_wd;
  logic [3:0]  m1_be;
  logic        m1_ack, m1_rvalid;
  logic [31:0] m1_rd;
  logic [31:0] bus_addr, bus_wd, bus_rd;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic        owner, busy;

  int n_chk  = 0;
  int n_pass = 0;

  bus_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .sys_rstn(sys_rstn),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wd(m0_wd), .m0_be(m0_be), .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wd(m1_wd), .m1_be(m1_be), .m1_ack(m1_ack), .m1_rd(m1_rd),
    .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_we(bus_we), .bus_be(bus_be),
    .bus_rd(bus_rd), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wd = '0; m0_be = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wd = '0; m1_be = '0;
    bus_rd = '0;
  endtask

  // Directed vectors: inputs {m0_req m0_lock m1_req m1_lock},
  // expected {m0_ack m1_ack owner busy}
  typedef struct packed {
    logic r0, l0, r1, l1;
    logic a0, a1, own, bsy;
  } vec_t;
  vec_t tbl[14];

  // Reference model: who owns the bus, how many transfers this tenure has
  // had, and which master most recently won ownership.
  int          md_cur;     // -1 = nobody
  int          md_last;
  int          md_streak;
  logic [31:0] md_rd[2];
  logic        md_rv[2];
  logic        e_ack[2];
  logic        rq[2], lk[2], wq[2];
  logic [31:0] ad[2], wd[2];
  logic [3:0]  be[2];

  task automatic new_fields(input int x);
    lk[x] = ($urandom_range(0, 3) != 0);
    wq[x] = 1'($urandom_range(0, 1));
    ad[x] = $urandom;
    wd[x] = $urandom;
    be[x] = 4'($urandom);
  endtask

  task automatic push();
    m0_req = rq[0]; m0_lock = lk[0]; m0_we = wq[0];
    m0_addr = ad[0]; m0_wd = wd[0]; m0_be = be[0];
    m1_req = rq[1]; m1_lock = lk[1]; m1_we = wq[1];
    m1_addr = ad[1]; m1_wd = wd[1]; m1_be = be[1];
  endtask

  initial begin
    int          win[10];
    int          k, m1_n;
    int          sel, nxt, x, o;
    logic [31:0] e_addr, e_wd;
    logic        e_we;
    logic [3:0]  e_be;

    tbl[0]  = 8'b0000_0000;
    tbl[1]  = 8'b1000_0000;
    tbl[2]  = 8'b1000_1001;
    tbl[3]  = 8'b1010_1001;
    tbl[4]  = 8'b1010_0111;
    tbl[5]  = 8'b1010_1001;
    tbl[6]  = 8'b1000_0011;
    tbl[7]  = 8'b0000_0001;
    tbl[8]  = 8'b0000_0000;
    tbl[9]  = 8'b1011_0000;
    tbl[10] = 8'b1011_0111;
    tbl[11] = 8'b1010_0111;
    tbl[12] = 8'b1110_1001;
    tbl[13] = 8'b0000_0001;

    // ---- reset values, with M0 already requesting a read ----
    clear_inputs();
    sys_rstn = 1'b1;
    #1 sys_rstn = 1'b0;
    m0_req = 1; m0_addr = 32'h0000_3000; bus_rd = 32'h1234_5678;
    #1;
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_m0_rd", m0_rd, 0);
    chk("rst_m1_rd", m1_rd, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_owner_busy", {owner, busy}, 0);
    step(); step();
    @(negedge clk);
    sys_rstn = 1'b1;

    // ---- first read: ack in cycle 1, data in cycle 2 ----
    #1 chk("rd_c0_ack", m0_ack, 0);
    step();
    @(negedge clk);
    chk("rd_c1_ack", m0_ack, 1);
    chk("rd_c1_addr", bus_addr, 32'h0000_3000);
    chk("rd_c1_we", bus_we, 0);
    chk("rd_c1_owner_busy", {owner, busy}, 2'b01);
    step();
    m0_req = 0;
    @(negedge clk);
    chk("rd_c2_rvalid", m0_rvalid, 1);
    chk("rd_c2_rd", m0_rd, 32'h1234_5678);
    step();
    @(negedge clk);
    chk("rd_c3_rvalid", m0_rvalid, 0);

    // ---- vector table ----
    step();
    m0_we = 1; m0_addr = 32'h0000_0100; m1_we = 0; m1_addr = 32'h0000_0200;
    for (int i = 0; i < 14; i++) begin
      {m0_req, m0_lock, m1_req, m1_lock} = {tbl[i].r0, tbl[i].l0, tbl[i].r1, tbl[i].l1};
      @(negedge clk);
      chk($sformatf("vec%0d_acks", i), {m0_ack, m1_ack}, {tbl[i].a0, tbl[i].a1});
      chk($sformatf("vec%0d_owner_busy", i), {owner, busy}, {tbl[i].own, tbl[i].bsy});
      chk($sformatf("vec%0d_bus_we", i), bus_we, tbl[i].a0);
      step();
    end
    clear_inputs();

    // ---- locked M1 burst of 20 writes against a continuously waiting M0 ----
    m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 32'h0000_4000; m1_wd = 0;
    @(negedge clk);
    chk("burst_idle_ack", m1_ack, 0);
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_1000;
    k = 0; m1_n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      chk("burst_one_ack", m0_ack ^ m1_ack, 1);
      if (k < 10) win[k] = m1_ack ? 1 : 0;
      k++;
      if (m1_ack) m1_n++;
      step();
      m1_wd = m1_n;
      if (m1_n == 20) begin
        m1_req = 0;
        break;
      end
    end
    chk("burst_m1_total", m1_n, 20);
    for (int i = 0; i < 10; i++)
      chk($sformatf("burst_seq%0d", i), win[i], (i == 8) ? 0 : 1);
    m0_req = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!busy) break;
      step();
    end
    chk("burst_back_idle", busy, 0);
    step();
    clear_inputs();

    // ---- M0 alone: four back-to-back writes ----
    m0_req = 1; m0_we = 1; m0_be = 4'b0001; m0_addr = 32'h0000_2000; m0_wd = 32'h11;
    @(negedge clk);
    chk("wr_idle_ack", m0_ack, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      m0_wd = 32'(17 * (i + 1));
      @(negedge clk);
      chk($sformatf("wr%0d_ack", i), m0_ack, 1);
      chk($sformatf("wr%0d_we", i), bus_we, 1);
      chk($sformatf("wr%0d_wd", i), bus_wd, 32'(17 * (i + 1)));
      chk($sformatf("wr%0d_be", i), bus_be, 4'b0001);
      chk($sformatf("wr%0d_rvalid", i), m0_rvalid, 0);
    end
    step();
    m0_req = 0;
    @(negedge clk);
    chk("wr_after_rvalid", m0_rvalid, 0);
    chk("wr_after_we", bus_we, 0);
    step();
    @(negedge clk);
    chk("wr_idle_busy", busy, 0);
    step();

    // ---- reset during an M1 read ----
    clear_inputs();
    m1_req = 1; m1_we = 0; m1_addr = 32'h0000_5000; m1_be = 4'hF; bus_rd = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstmid_idle_ack", m1_ack, 0);
    step();
    @(negedge clk);
    chk("rstmid_ack_before", m1_ack, 1);
    chk("rstmid_addr_before", bus_addr, 32'h0000_5000);
    #2 sys_rstn = 1'b0;
    #1;
    chk("rstmid_ack", m1_ack, 0);
    chk("rstmid_addr", bus_addr, 0);
    chk("rstmid_we_be", {bus_we, bus_be}, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    sys_rstn = 1'b1;
    m1_req = 0;
    #1 chk("rstmid_rvalid0", m1_rvalid, 0);
    step();
    @(negedge clk);
    chk("rstmid_rvalid1", m1_rvalid, 0);
    m0_req = 1; m1_req = 1;
    step();
    @(negedge clk);
    chk("rstmid_tie_acks", {m0_ack, m1_ack}, 2'b10);
    step();
    clear_inputs();
    step();
    step();

    // ---- quiet bus for 10 cycles ----
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("quiet%0d", i), {busy, bus_we, bus_addr}, 0);
      step();
    end

    // ---- random traffic against the reference model ----
    sys_rstn = 1'b0;
    step();
    @(negedge clk);
    sys_rstn = 1'b1;
    md_cur = -1; md_last = 1; md_streak = 0;
    for (int i = 0; i < 2; i++) begin
      md_rd[i] = '0; md_rv[i] = 0; e_ack[i] = 0;
      rq[i] = 0; lk[i] = 0; wq[i] = 0; ad[i] = '0; wd[i] = '0; be[i] = '0;
    end
    step();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      // Masters hold a request until acked, then renew or drop it.
      for (int i = 0; i < 2; i++) begin
        if (rq[i]) begin
          if (e_ack[i]) begin
            if ($urandom_range(0, 3) != 0) new_fields(i);
            else rq[i] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rq[i] = 1;
          new_fields(i);
        end
      end
      push();
      bus_rd = $urandom;
      @(negedge clk);

      e_ack[0] = (md_cur == 0) && rq[0];
      e_ack[1] = (md_cur == 1) && rq[1];
      sel = e_ack[0] ? 0 : (e_ack[1] ? 1 : -1);
      e_addr = (sel >= 0) ? ad[sel] : '0;
      e_wd   = (sel >= 0) ? wd[sel] : '0;
      e_we   = (sel >= 0) ? wq[sel] : 1'b0;
      e_be   = (sel >= 0) ? be[sel] : '0;
      chk("rnd_acks", {m0_ack, m1_ack}, {e_ack[0], e_ack[1]});
      chk("rnd_bus_addr", bus_addr, e_addr);
      chk("rnd_bus_wd", bus_wd, e_wd);
      chk("rnd_bus_we_be", {bus_we, bus_be}, {e_we, e_be});
      chk("rnd_owner", owner, md_cur == 1);
      chk("rnd_busy", busy, md_cur != -1);
      chk("rnd_rvalid", {m0_rvalid, m1_rvalid}, {md_rv[0], md_rv[1]});
      chk("rnd_m0_rd", m0_rd, md_rd[0]);
      chk("rnd_m1_rd", m1_rd, md_rd[1]);

      // Advance the model to the next cycle.
      for (int i = 0; i < 2; i++) begin
        md_rv[i] = e_ack[i] && !wq[i];
        if (md_rv[i]) md_rd[i] = bus_rd;
      end
      nxt = md_cur;
      if (md_cur < 0) begin
        if (rq[0] && rq[1]) nxt = 1 - md_last;
        else if (rq[0])     nxt = 0;
        else if (rq[1])     nxt = 1;
      end else begin
        x = md_cur;
        o = 1 - x;
        if (!rq[x])
          nxt = rq[o] ? o : -1;
        else if (rq[o] && (!lk[x] || (md_streak + 1 >= MB)))
          nxt = o;
      end
      if (nxt != md_cur) begin
        md_streak = 0;
        if (nxt >= 0) md_last = nxt;
      end else if (md_cur >= 0 && e_ack[md_cur]) begin
        md_streak++;
      end
      md_cur = nxt;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
